// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one bit per cycle.
//
// Ports
//   clk, rst        clock, synchronous active-high reset (rst overrides flush)
//   flush           abort any operation in flight; also blocks acceptance in IDLE
//   in_valid/ready  request handshake; in_ready is high only in IDLE
//   in_a, in_b, op  operands and funct3 (MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU)
//   out_valid/ready result handshake; out_valid is high only in DONE
//   out             registered result, held until the next completed operation
//   busy            high while an operation is in CALC or DONE
//
// Operation flow: the accept edge latches raw operands and their signs. The first
// CALC cycle folds the operands to magnitudes (keeping negation off the input path)
// and resolves the divide special cases straight to DONE. Otherwise WIDTH step
// cycles follow, the last of which loads the sign-corrected result into out.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_n;
  logic                 prep_q;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     out_r;
  logic [2:0]           op_q;
  logic                 sa_q, sb_q;
  // hi:lo is the product register for multiply and remainder:quotient for divide.
  // mag holds the multiplicand or the divisor.
  logic [WIDTH-1:0]     hi, lo, mag;

  logic                 accept;
  logic                 sgn_a, sgn_b;
  logic                 special;
  logic [WIDTH-1:0]     special_res;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;
  logic [WIDTH-1:0]     hi_n, lo_n;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     final_res;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out       = out_r;
  assign accept    = in_valid && (state == IDLE) && !flush;

  // Signed rs1 for MULH, MULHSU, DIV, REM; signed rs2 for MULH, DIV, REM.
  assign sgn_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign sgn_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);

  // During the first CALC cycle lo/mag still hold the raw dividend/divisor.
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (op_q[2]) begin
      if (mag == '0) begin
        special     = 1'b1;
        special_res = op_q[1] ? lo : '1;
      end else if (!op_q[0] && lo == MIN_NEG && mag == '1) begin
        special     = 1'b1;
        special_res = op_q[1] ? '0 : lo;
      end
    end
  end

  // One iteration step. The divide subtract is WIDTH+1 bits: because the partial
  // remainder is always below the divisor, shifted < 2*divisor, so the top bit of
  // the difference is set exactly when the subtraction borrows.
  always_comb begin
    mul_sum = lo[0] ? ({1'b0, hi} + {1'b0, mag}) : {1'b0, hi};
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, mag};
    if (op_q[2]) begin
      hi_n = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo[WIDTH-1:1]};
    end
    prod = neg2_if({hi_n, lo_n}, sa_q ^ sb_q);
    case (op_q)
      3'b000:                 final_res = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         final_res = neg_if(lo_n, sa_q ^ sb_q);
      default:                final_res = neg_if(hi_n, sa_q);
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = CALC;
      CALC: begin
        if (flush)                      state_n = IDLE;
        else if (prep_q && special)     state_n = DONE;
        else if (!prep_q && cnt == '0)  state_n = DONE;
      end
      DONE: if (flush || out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      prep_q <= 1'b0;
      cnt    <= '0;
      out_r  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        prep_q <= 1'b1;
        cnt    <= CW'(WIDTH - 1);
      end else if (state == CALC && !flush) begin
        if (prep_q) begin
          prep_q <= 1'b0;
          if (special) out_r <= special_res;
        end else begin
          cnt <= cnt - CW'(1);
          if (cnt == '0) out_r <= final_res;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= op;
      sa_q <= sgn_a & in_a[WIDTH-1];
      sb_q <= sgn_b & in_b[WIDTH-1];
      hi   <= '0;
      lo   <= op[2] ? in_a : in_b;
      mag  <= op[2] ? in_b : in_a;
    end else if (state == CALC && !flush) begin
      if (prep_q) begin
        lo  <= neg_if(lo,  op_q[2] ? sa_q : sb_q);
        mag <= neg_if(mag, op_q[2] ? sb_q : sa_q);
      end else begin
        hi <= hi_n;
        lo <= lo_n;
      end
    end
  end

endmodule
